// File: rtl/width_lane_arbiter.sv
// Three-lane (16/8/4-bit) round-robin arbiter with bounded bursts onto one registered sink.
// Narrow lanes are zero- or sign-extended and every beat is tagged with its source lane.
module width_lane_arbiter #(
    parameter int unsigned OUT_WIDTH    = 16,
    parameter int unsigned WIDE_WIDTH   = 16,
    parameter int unsigned MID_WIDTH    = 8,
    parameter int unsigned NARROW_WIDTH = 4,
    parameter int unsigned BURST_LEN    = 2,
    parameter int unsigned SIGN_EXT     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in16_valid,
    input  logic [WIDE_WIDTH-1:0]   in16_data,
    output logic                    in16_ready,
    input  logic                    in8_valid,
    input  logic [MID_WIDTH-1:0]    in8_data,
    output logic                    in8_ready,
    input  logic                    in4_valid,
    input  logic [NARROW_WIDTH-1:0] in4_data,
    output logic                    in4_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [1:0]              out_lane
);

    localparam logic [0:0]           StIdle   = 1'b0;
    localparam logic [0:0]           StOwn    = 1'b1;
    localparam logic [3:0]           BurstMax = 4'(BURST_LEN);
    localparam logic [OUT_WIDTH-1:0] Ones     = '1;

    logic [0:0]           state_q, state_d;
    logic [1:0]           last_grant_q, last_grant_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]           out_lane_q, out_lane_d;

    logic [2:0]           lane_valid;
    logic                 load_en, gnt_vld, accept;
    logic [1:0]           gnt_lane, rr_c0, rr_c1, rr_c2;
    logic [OUT_WIDTH-1:0] ext16, ext8, ext4, gnt_data;

    function automatic logic [1:0] next_lane(input logic [1:0] l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

    assign lane_valid = {in4_valid, in8_valid, in16_valid};
    assign load_en    = !out_valid_q || out_ready;

    // The owner keeps the grant while valid and under budget; every other case (idle, owner
    // dropped, budget spent) is a round-robin search starting just after the last grant.
    always_comb begin
        rr_c0    = next_lane(last_grant_q);
        rr_c1    = next_lane(rr_c0);
        rr_c2    = next_lane(rr_c1);
        gnt_vld  = 1'b1;
        gnt_lane = rr_c0;
        if (state_q == StOwn && lane_valid[last_grant_q] && burst_cnt_q < BurstMax) begin
            gnt_lane = last_grant_q;
        end else if (lane_valid[rr_c0]) begin
            gnt_lane = rr_c0;
        end else if (lane_valid[rr_c1]) begin
            gnt_lane = rr_c1;
        end else if (lane_valid[rr_c2]) begin
            gnt_lane = rr_c2;
        end else begin
            gnt_vld = 1'b0;
        end
    end

    assign accept     = load_en && gnt_vld;
    assign in16_ready = accept && (gnt_lane == 2'd0);
    assign in8_ready  = accept && (gnt_lane == 2'd1);
    assign in4_ready  = accept && (gnt_lane == 2'd2);

    always_comb begin
        ext16 = OUT_WIDTH'(in16_data);
        ext8  = OUT_WIDTH'(in8_data);
        ext4  = OUT_WIDTH'(in4_data);
        if (SIGN_EXT != 0) begin
            if (in16_data[WIDE_WIDTH-1])  ext16 = ext16 | (Ones << WIDE_WIDTH);
            if (in8_data[MID_WIDTH-1])    ext8  = ext8 | (Ones << MID_WIDTH);
            if (in4_data[NARROW_WIDTH-1]) ext4  = ext4 | (Ones << NARROW_WIDTH);
        end
        case (gnt_lane)
            2'd0:    gnt_data = ext16;
            2'd1:    gnt_data = ext8;
            default: gnt_data = ext4;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_lane_d   = out_lane_q;
        if (accept) begin
            if (state_q == StOwn && gnt_lane == last_grant_q) begin
                burst_cnt_d = (burst_cnt_q < BurstMax) ? burst_cnt_q + 4'd1 : BurstMax;
            end else begin
                burst_cnt_d = 4'd1;
            end
            state_d      = StOwn;
            last_grant_d = gnt_lane;
            out_valid_d  = 1'b1;
            out_data_d   = gnt_data;
            out_lane_d   = gnt_lane;
        end else begin
            if (out_ready) out_valid_d = 1'b0;
            if (state_q == StOwn && !gnt_vld) begin
                state_d     = StIdle;
                burst_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 2'd2;
            burst_cnt_q  <= 4'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_lane_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_lane_q   <= out_lane_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;

endmodule

// File: doc/width_lane_arbiter.md
Name: width_lane_arbiter

Overview:
- Shares one 16-bit sink port between three producers of different widths: 16-bit, 8-bit and 4-bit lanes.
- Arbitrates round-robin with bounded bursts.
- Extends narrow lanes to the sink width and tags each beat with its source lane.
- Sits between width_source-style producers and a single width_sink-style consumer.

Parameters:
- OUT_WIDTH, 16, sink data width; must be >= WIDE_WIDTH.
- WIDE_WIDTH, 16, lane 0 data width.
- MID_WIDTH, 8, lane 1 data width.
- NARROW_WIDTH, 4, lane 2 data width.
- BURST_LEN, 2, max consecutive beats one lane may win while others wait; 1..15.
- SIGN_EXT, 0, 0 = zero-extend narrow lanes, 1 = sign-extend from lane MSB.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in16_valid  input  1  lane 0 beat valid.
- in16_data  input  WIDE_WIDTH  lane 0 data.
- in16_ready  output  1  lane 0 beat accepted this cycle.
- in8_valid  input  1  lane 1 beat valid.
- in8_data  input  MID_WIDTH  lane 1 data.
- in8_ready  output  1  lane 1 beat accepted.
- in4_valid  input  1  lane 2 beat valid.
- in4_data  input  NARROW_WIDTH  lane 2 data.
- in4_ready  output  1  lane 2 beat accepted.
- out_valid  output  1  registered beat present.
- out_ready  input  1  sink accepts beat.
- out_data  output  OUT_WIDTH  extended beat data.
- out_lane  output  2  source lane of out_data (0/1/2; 3 never driven).

Behaviour:
- Reset (rst_n low at clk edge):
  - out_valid=0, out_data=0, out_lane=0.
  - Round-robin pointer last_grant=2, so lane 0 has top priority.
  - Burst counter burst_cnt=0; owner state IDLE.
  - A beat held in the output register is discarded.
- Handshakes:
  - Valid/ready on all ports; transfer when valid && ready on the same edge.
  - Producers hold valid and data stable until accepted.
  - Sink side: out_valid/out_data/out_lane stay stable until out_ready.
- Load enable: load_en = !out_valid || out_ready. Full throughput of 1 beat/cycle with out_ready held high.
- in*_ready:
  - Combinational: asserted only for the granted lane, and only when load_en=1 and that lane is valid.
  - At most one ready high per cycle; never high when load_en=0.
  - ready may depend on the valids of all lanes.
- Latency: accepted beat appears on out_* on the next edge (1 cycle).
- Extension:
  - Lane data is placed in LSBs.
  - Upper bits are 0, or copies of the lane MSB when SIGN_EXT=1.
  - Lane 0 is extended only if OUT_WIDTH > WIDE_WIDTH.
- Owner FSM:
  - IDLE: grant the first valid lane in round-robin order starting at last_grant+1 mod 3. On accept, go to OWN(lane), burst_cnt=1, last_grant=lane.
  - OWN(L), L still valid and burst_cnt < BURST_LEN: L keeps the grant. On accept, burst_cnt++.
  - OWN(L), burst_cnt == BURST_LEN and another lane valid: round-robin grant from L+1. Winner becomes owner with burst_cnt=1 on accept.
  - OWN(L), burst_cnt == BURST_LEN and no other lane valid: L continues; burst_cnt holds at BURST_LEN.
  - OWN(L), L drops valid: arbitrate round-robin from L+1 in the same cycle (no idle bubble). If nothing is valid, go to IDLE with burst_cnt=0.
- Grant and counter stability:
  - The grant decision is combinational from state plus valids, so it may change on a cycle with load_en=0 (no transfer).
  - State advances only on accepted beats or an owner valid drop.
- Empty: no lane valid -> no readies. out_valid drops after the pending beat drains.
- Back-pressure: out_ready=0 with out_valid=1 -> all readies 0, output and FSM frozen.
- Reset mid-burst or mid-stall: all state returns to reset values on that edge. The first post-reset grant goes to lane 0 if valid.

Test Plan:
- Single beat, SIGN_EXT=0: in8_valid=1, in8_data=0xA5 -> in8_ready=1 at cycle 0; cycle 1 out_valid=1, out_data=0x00A5, out_lane=1.
- Sign extension, SIGN_EXT=1: in4_data=0x9 -> out_data=0xFFF9, out_lane=2. in8_data=0x7F -> out_data=0x007F.
- Fairness, BURST_LEN=2: all three lanes valid continuously, out_ready=1 -> out_lane sequence 0,0,1,1,2,2,0,0 with no idle cycles; each ready high exactly 2 of every 6 cycles.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1, lanes valid -> all in*_ready=0, out_data/out_lane constant, no beat lost or duplicated (scoreboard count match).
- Owner drop mid-burst: lane 0 owns with burst_cnt=1, in16_valid drops, lane 2 valid -> lane 2 granted the same cycle, next burst_cnt=1, out_lane=2 following.
- Reset mid-operation: rst_n=0 for 1 cycle while out_valid=1, burst_cnt=1 on lane 1 -> next cycle out_valid=0, out_data=0; with lanes 1 and 0 both valid after release, the first beat is out_lane=0.
